// File: rtl/bada_acc_pkg.sv
// Shared constants and lane helper for the BADA operand packer, adder tree and their benches.
package bada_acc_pkg;

  localparam int DEFAULT_N_INPUT  = 4;
  localparam int DEFAULT_OP_WIDTH = 4;
  localparam int N_STAGE          = $clog2(DEFAULT_N_INPUT);
  localparam int INPUT_WIDTH      = DEFAULT_N_INPUT * DEFAULT_OP_WIDTH;
  localparam int OUTPUT_WIDTH     = DEFAULT_OP_WIDTH + N_STAGE;

  function automatic logic [DEFAULT_OP_WIDTH-1:0] lane_slice(
    input logic [INPUT_WIDTH-1:0] bus,
    input int                     lane
  );
    return bus[DEFAULT_OP_WIDTH*lane +: DEFAULT_OP_WIDTH];
  endfunction

endpackage

// File: rtl/bada_group_reg.sv
// Output register for one packed group, holding data and valid until the tree side accepts it.
module bada_group_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // A load only arrives when the held group drains this cycle or the register is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bada_operand_packer.sv
// Packs N_INPUT operands into one flat lane bus for the BADA adder tree.
// Optional PACKER_LAST_EN adds i_last (early group close) and o_lane_mask.
module bada_operand_packer
  import bada_acc_pkg::*;
#(
  parameter int N_INPUT  = DEFAULT_N_INPUT,
  parameter int OP_WIDTH = DEFAULT_OP_WIDTH
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [OP_WIDTH-1:0]         i_op,
`ifdef PACKER_LAST_EN
  input  logic                        i_last,
`endif
  output logic                        o_valid,
  input  logic                        i_ready,
`ifdef PACKER_LAST_EN
  output logic [N_INPUT*OP_WIDTH-1:0] o_data,
  output logic [N_INPUT-1:0]          o_lane_mask
`else
  output logic [N_INPUT*OP_WIDTH-1:0] o_data
`endif
);

  localparam int CNT_W = $clog2(N_INPUT);
  localparam int BUS_W = N_INPUT * OP_WIDTH;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(N_INPUT - 1);

  generate
    if (N_INPUT < 2 || (N_INPUT & (N_INPUT - 1)) != 0) begin : g_bad_n_input
      $error("bada_operand_packer: N_INPUT must be a power of two and >= 2");
    end
  endgenerate

  logic [CNT_W-1:0] cnt;
  logic [BUS_W-1:0] collect;
  logic [BUS_W-1:0] group_data;
  logic             closing;
  logic             accept;
  logic             complete;

`ifdef PACKER_LAST_EN
  assign closing = (cnt == LAST_LANE) || i_last;
`else
  assign closing = (cnt == LAST_LANE);
`endif

  // Stall only when a completing operand would overwrite a group the tree has not taken.
  assign o_ready  = !(closing && o_valid && !i_ready);
  assign accept   = i_valid && o_ready;
  assign complete = accept && closing;

  always_comb begin
    group_data = collect;
    group_data[OP_WIDTH*cnt +: OP_WIDTH] = i_op;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt     <= '0;
      collect <= '0;
    end else if (complete) begin
      cnt     <= '0;
      collect <= '0;
    end else if (accept) begin
      cnt     <= cnt + 1'b1;
      collect <= group_data;
    end
  end

`ifdef PACKER_LAST_EN
  logic [N_INPUT-1:0] group_mask;

  always_comb begin
    group_mask = '0;
    for (int i = 0; i < N_INPUT; i++) begin
      group_mask[i] = (CNT_W'(i) <= cnt);
    end
  end

  localparam int REG_W = BUS_W + N_INPUT;
  logic [REG_W-1:0] held;
  assign {o_lane_mask, o_data} = held;

  bada_group_reg #(.WIDTH(REG_W)) u_group_reg (
    .clk       (i_clk),
    .rst_n     (i_rstn),
    .load      (complete),
    .load_data ({group_mask, group_data}),
    .ready     (i_ready),
    .valid     (o_valid),
    .data      (held)
  );
`else
  bada_group_reg #(.WIDTH(BUS_W)) u_group_reg (
    .clk       (i_clk),
    .rst_n     (i_rstn),
    .load      (complete),
    .load_data (group_data),
    .ready     (i_ready),
    .valid     (o_valid),
    .data      (o_data)
  );
`endif

endmodule

// File: tb/tb_bada_operand_packer.sv
// Directed self-checking bench for bada_operand_packer (N_INPUT=4, OP_WIDTH=4).
module tb_bada_operand_packer;
  import bada_acc_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [3:0]  i_op = 4'h0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [15:0] o_data;
`ifdef PACKER_LAST_EN
  logic        i_last = 1'b0;
  logic [3:0]  o_lane_mask;
`endif

  int checks = 0;
  int passed = 0;
  int stall_cycles = 0;

  always #5 i_clk = ~i_clk;

  bada_operand_packer #(.N_INPUT(4), .OP_WIDTH(4)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_op        (i_op),
`ifdef PACKER_LAST_EN
    .i_last      (i_last),
    .o_lane_mask (o_lane_mask),
`endif
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data)
  );

  // Presents one operand at the falling edge and returns just after the edge that takes it.
  task automatic send(input logic [3:0] op);
    int waited = 0;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_op    = op;
    #1;
    while (!o_ready && waited < 20) begin
      @(negedge i_clk);
      #1;
      waited++;
    end
    stall_cycles += waited;
    checks++;
    if (o_ready !== 1'b1) $display("FAIL send_accept op=%h o_ready=%b required=1", op, o_ready);
    else passed++;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    @(negedge i_clk);
    i_valid = 1'b0;
`ifdef PACKER_LAST_EN
    i_last = 1'b0;
`endif
  endtask

  task automatic test_reset();
    i_rstn = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if (o_valid !== 1'b0) $display("FAIL reset_held_valid o_valid=%b required=0", o_valid);
    else passed++;
    @(negedge i_clk);
    i_rstn = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0) $display("FAIL reset_valid o_valid=%b required=0", o_valid);
    else passed++;
    checks++;
    if (o_data !== 16'h0000) $display("FAIL reset_data o_data=%h required=0000", o_data);
    else passed++;
    checks++;
    if (o_ready !== 1'b1) $display("FAIL reset_ready o_ready=%b required=1", o_ready);
    else passed++;
`ifdef PACKER_LAST_EN
    checks++;
    if (o_lane_mask !== 4'b0000) $display("FAIL reset_mask o_lane_mask=%b required=0000", o_lane_mask);
    else passed++;
`endif
  endtask

  task automatic test_ones();
    int sum = 0;
    i_ready = 1'b1;
    repeat (4) send(4'h1);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 16'h1111)
      $display("FAIL ones_group o_valid=%b o_data=%h required=1/1111", o_valid, o_data);
    else passed++;
    for (int i = 0; i < 4; i++) sum += int'(lane_slice(o_data, i));
    checks++;
    if (sum !== 4) $display("FAIL ones_tree_sum sum=%0d required=4", sum);
    else passed++;
    idle();
    @(posedge i_clk);
    #1;
    checks++;
    if (o_valid !== 1'b0) $display("FAIL ones_drain o_valid=%b required=0", o_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b1;
    stall_cycles = 0;
    for (int i = 1; i <= 4; i++) send(4'(i));
    checks++;
    if (o_valid !== 1'b1 || o_data !== 16'h4321)
      $display("FAIL b2b_first o_valid=%b o_data=%h required=1/4321", o_valid, o_data);
    else passed++;
    for (int i = 5; i <= 8; i++) send(4'(i));
    checks++;
    if (o_valid !== 1'b1 || o_data !== 16'h8765)
      $display("FAIL b2b_second o_valid=%b o_data=%h required=1/8765", o_valid, o_data);
    else passed++;
    checks++;
    if (stall_cycles !== 0) $display("FAIL b2b_no_stall stalls=%0d required=0", stall_cycles);
    else passed++;
    idle();
    @(posedge i_clk);
    #1;
    checks++;
    if (o_valid !== 1'b0) $display("FAIL b2b_drain o_valid=%b required=0", o_valid);
    else passed++;
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(4'(i));
    for (int i = 5; i <= 7; i++) send(4'(i));
    @(negedge i_clk);
    i_op = 4'h8;
    #1;
    checks++;
    if (o_ready !== 1'b0) $display("FAIL bp_stall o_ready=%b required=0", o_ready);
    else passed++;
    @(negedge i_clk);
    #1;
    checks++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== 16'h4321)
      $display("FAIL bp_hold o_ready=%b o_valid=%b o_data=%h required=0/1/4321", o_ready, o_valid, o_data);
    else passed++;
    i_ready = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1) $display("FAIL bp_release o_ready=%b required=1", o_ready);
    else passed++;
    @(posedge i_clk);
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_data !== 16'h8765)
      $display("FAIL bp_reload o_valid=%b o_data=%h required=1/8765", o_valid, o_data);
    else passed++;
    idle();
    @(posedge i_clk);
    #1;
    checks++;
    if (o_valid !== 1'b0) $display("FAIL bp_drain o_valid=%b required=0", o_valid);
    else passed++;
  endtask

  task automatic test_reset_mid_group();
    i_ready = 1'b1;
    send(4'h1);
    send(4'h2);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_rstn  = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== 16'h0000)
      $display("FAIL midrst_state o_ready=%b o_valid=%b o_data=%h required=1/0/0000", o_ready, o_valid, o_data);
    else passed++;
    @(negedge i_clk);
    i_rstn = 1'b1;
    send(4'hF);
    send(4'hE);
    send(4'hD);
    send(4'hC);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 16'hCDEF)
      $display("FAIL midrst_group o_valid=%b o_data=%h required=1/cdef", o_valid, o_data);
    else passed++;
`ifdef PACKER_LAST_EN
    checks++;
    if (o_lane_mask !== 4'b1111) $display("FAIL full_mask o_lane_mask=%b required=1111", o_lane_mask);
    else passed++;
`endif
    idle();
    @(posedge i_clk);
    #1;
  endtask

`ifdef PACKER_LAST_EN
  task automatic test_last();
    i_ready = 1'b1;
    i_last  = 1'b0;
    send(4'h9);
    i_last = 1'b1;
    send(4'hA);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 16'h00A9 || o_lane_mask !== 4'b0011)
      $display("FAIL last_group o_valid=%b o_data=%h mask=%b required=1/00a9/0011", o_valid, o_data, o_lane_mask);
    else passed++;
    idle();
    send(4'h5);
    send(4'h6);
    send(4'h7);
    send(4'h8);
    checks++;
    if (o_data !== 16'h8765 || o_lane_mask !== 4'b1111)
      $display("FAIL last_followup o_data=%h mask=%b required=8765/1111", o_data, o_lane_mask);
    else passed++;
    idle();
    @(posedge i_clk);
    #1;
  endtask
`endif

  initial begin
    test_reset();
    test_ones();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_group();
`ifdef PACKER_LAST_EN
    test_last();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
